// File: rtl/mem_arbiter_pkg.sv
// Shared types for the ay8 data-memory subsystem: direction encoding and arbiter states.
// Imported by the memory, the CPU requesters and the arbiter.
package ay8_mem_pkg;

  localparam logic RW_READ  = 1'b1;
  localparam logic RW_WRITE = 1'b0;

  // Width of the read watchdog; wide enough for the largest TIMEOUT of 255.
  localparam int WDOG_W = 8;

  typedef enum logic [1:0] {ARB_IDLE, ARB_ISSUE, ARB_WAIT, ARB_ACK} arb_state_t;

endpackage

// File: rtl/mem_arbiter_if.sv
// Bundle of requester-side and memory-side signals around the shared data memory.
// The slave modport is the arbiter's view; master is the requesters/memory view.
interface mem_arbiter_if
  import ay8_mem_pkg::*;
#(
  parameter int N_REQ = 2,
  parameter int AW    = 8,
  parameter int DW    = 8
) ();

  localparam int IW = $clog2(N_REQ);

  logic [N_REQ-1:0]    req;
  logic [N_REQ-1:0]    rw;
  logic [N_REQ*AW-1:0] addr;
  logic [N_REQ*DW-1:0] wdata;
  logic [N_REQ-1:0]    ack;
  logic [DW-1:0]       rdata;
  logic                err;
  logic                busy;
  logic [IW-1:0]       gnt_id;

  logic                mem_start;
  logic                mem_rw;
  logic [AW-1:0]       mem_addr;
  logic [DW-1:0]       mem_wdata;
  logic [DW-1:0]       mem_rdata;
  logic                mem_rvalid;

  modport slave (
    input  req, rw, addr, wdata, mem_rdata, mem_rvalid,
    output ack, rdata, err, busy, gnt_id, mem_start, mem_rw, mem_addr, mem_wdata
  );

  modport master (
    output req, rw, addr, wdata, mem_rdata, mem_rvalid,
    input  ack, rdata, err, busy, gnt_id, mem_start, mem_rw, mem_addr, mem_wdata
  );

endinterface

// File: rtl/mem_arbiter_rr_pick.sv
// Combinational round-robin selector: first active request at or after rr_ptr,
// wrapping modulo N_REQ.
module rr_pick
  import ay8_mem_pkg::*;
#(
  parameter int N_REQ = 2,
  localparam int IW   = $clog2(N_REQ)
) (
  input  logic [N_REQ-1:0] req,
  input  logic [IW-1:0]    rr_ptr,
  output logic             valid,
  output logic [IW-1:0]    idx
);

  // Scan from the farthest offset down so the nearest requester wins last.
  always_comb begin : pick
    logic [IW:0]   sum;
    logic [IW-1:0] cand;
    valid = 1'b0;
    idx   = '0;
    sum   = '0;
    cand  = '0;
    for (int i = N_REQ - 1; i >= 0; i--) begin
      sum = {1'b0, rr_ptr} + (IW+1)'(i);
      if (sum >= (IW+1)'(N_REQ)) begin
        sum = sum - (IW+1)'(N_REQ);
      end
      cand = sum[IW-1:0];
      if (req[cand]) begin
        valid = 1'b1;
        idx   = cand;
      end
    end
  end

endmodule

// File: rtl/mem_arbiter.sv
// Round-robin arbiter and sequencer sharing the single data memory between N_REQ
// requesters, one transaction at a time, with a read watchdog.
module mem_arbiter
  import ay8_mem_pkg::*;
#(
  parameter int N_REQ   = 2,
  parameter int AW      = 8,
  parameter int DW      = 8,
  parameter int TIMEOUT = 15
) (
  input  logic          clk,
  input  logic          rst,
  mem_arbiter_if.slave  bus
);

  localparam int IW = $clog2(N_REQ);

  arb_state_t          state_q, state_d;
  logic [IW-1:0]       rr_q, rr_d;
  logic [IW-1:0]       gnt_q, gnt_d;
  logic [WDOG_W-1:0]   cnt_q, cnt_d;
  logic [N_REQ-1:0]    ack_q, ack_d;
  logic                err_q, err_d;
  logic [DW-1:0]       rdata_q, rdata_d;
  logic                start_q, start_d;
  logic                mrw_q, mrw_d;
  logic [AW-1:0]       maddr_q, maddr_d;
  logic [DW-1:0]       mwdata_q, mwdata_d;

  logic                pick_valid;
  logic [IW-1:0]       pick_idx;

  rr_pick #(.N_REQ(N_REQ)) u_pick (
    .req    (bus.req),
    .rr_ptr (rr_q),
    .valid  (pick_valid),
    .idx    (pick_idx)
  );

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q  <= ARB_IDLE;
      rr_q     <= '0;
      gnt_q    <= '0;
      cnt_q    <= '0;
      ack_q    <= '0;
      err_q    <= 1'b0;
      rdata_q  <= '0;
      start_q  <= 1'b0;
      mrw_q    <= RW_READ;
      maddr_q  <= '0;
      mwdata_q <= '0;
    end else begin
      state_q  <= state_d;
      rr_q     <= rr_d;
      gnt_q    <= gnt_d;
      cnt_q    <= cnt_d;
      ack_q    <= ack_d;
      err_q    <= err_d;
      rdata_q  <= rdata_d;
      start_q  <= start_d;
      mrw_q    <= mrw_d;
      maddr_q  <= maddr_d;
      mwdata_q <= mwdata_d;
    end
  end

  // Next values are computed here so every output toggles straight off a flop.
  always_comb begin
    state_d  = state_q;
    rr_d     = rr_q;
    gnt_d    = gnt_q;
    cnt_d    = cnt_q;
    ack_d    = '0;
    err_d    = 1'b0;
    rdata_d  = rdata_q;
    start_d  = 1'b0;
    mrw_d    = mrw_q;
    maddr_d  = maddr_q;
    mwdata_d = mwdata_q;

    unique case (state_q)
      ARB_IDLE: begin
        if (pick_valid) begin
          gnt_d    = pick_idx;
          mrw_d    = bus.rw[pick_idx];
          maddr_d  = bus.addr[pick_idx*AW +: AW];
          mwdata_d = bus.wdata[pick_idx*DW +: DW];
          start_d  = 1'b1;
          state_d  = ARB_ISSUE;
        end
      end
      ARB_ISSUE: begin
        if (mrw_q == RW_READ) begin
          cnt_d   = '0;
          state_d = ARB_WAIT;
        end else begin
          ack_d[gnt_q] = 1'b1;
          state_d      = ARB_ACK;
        end
      end
      ARB_WAIT: begin
        // Data arriving on the timeout cycle still wins over the error.
        if (bus.mem_rvalid) begin
          rdata_d      = bus.mem_rdata;
          ack_d[gnt_q] = 1'b1;
          state_d      = ARB_ACK;
        end else if (cnt_q == WDOG_W'(TIMEOUT)) begin
          rdata_d      = '0;
          err_d        = 1'b1;
          ack_d[gnt_q] = 1'b1;
          state_d      = ARB_ACK;
        end else begin
          cnt_d = cnt_q + WDOG_W'(1);
        end
      end
      ARB_ACK: begin
        rr_d    = (gnt_q == IW'(N_REQ - 1)) ? '0 : gnt_q + IW'(1);
        state_d = ARB_IDLE;
      end
      default: state_d = ARB_IDLE;
    endcase
  end

  assign bus.ack       = ack_q;
  assign bus.err       = err_q;
  assign bus.rdata     = rdata_q;
  assign bus.busy      = (state_q != ARB_IDLE);
  assign bus.gnt_id    = gnt_q;
  assign bus.mem_start = start_q;
  assign bus.mem_rw    = mrw_q;
  assign bus.mem_addr  = maddr_q;
  assign bus.mem_wdata = mwdata_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter with a one-cycle 256x8 memory model that can be
// silenced (watchdog) or overridden (boundary / spurious rvalid).
module tb_mem_arbiter;
  import ay8_mem_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b0;
  int   checks = 0;
  int   failures = 0;

  logic       mem_en = 1'b1;
  logic       force_rvalid = 1'b0;
  logic [7:0] force_rdata = 8'h00;
  logic       model_rvalid;
  logic [7:0] model_rdata;
  logic [7:0] mem [256];

  mem_arbiter_if #(.N_REQ(2), .AW(8), .DW(8)) bus ();

  mem_arbiter #(.N_REQ(2), .AW(8), .DW(8), .TIMEOUT(15)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  always #5 clk = ~clk;

  assign bus.mem_rvalid = model_rvalid | force_rvalid;
  assign bus.mem_rdata  = force_rvalid ? force_rdata : model_rdata;

  // Memory answers a read one cycle after mem_start; contents are addr^0x66 after reset.
  always @(posedge clk) begin
    if (!rst) begin
      for (int i = 0; i < 256; i++) mem[i] <= 8'(i) ^ 8'h66;
      model_rvalid <= 1'b0;
      model_rdata  <= 8'h00;
    end else begin
      model_rvalid <= bus.mem_start && (bus.mem_rw == RW_READ) && mem_en;
      model_rdata  <= mem[bus.mem_addr];
      if (bus.mem_start && (bus.mem_rw == RW_WRITE)) mem[bus.mem_addr] <= bus.mem_wdata;
    end
  end

  task automatic applyStimulus(input logic [1:0] r, input logic [1:0] d,
                               input logic [15:0] a, input logic [15:0] w);
    bus.req   = r;
    bus.rw    = d;
    bus.addr  = a;
    bus.wdata = w;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("[TB] FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick(input int n = 1);
    repeat (n) @(negedge clk);
  endtask

  initial begin
    applyStimulus(2'b00, 2'b00, 16'h0000, 16'h0000);
    tick(3);
    checkOutput("rst_ack", 32'(bus.ack), 0);
    checkOutput("rst_err", 32'(bus.err), 0);
    checkOutput("rst_rdata", 32'(bus.rdata), 0);
    checkOutput("rst_start", 32'(bus.mem_start), 0);
    checkOutput("rst_mrw", 32'(bus.mem_rw), 1);
    checkOutput("rst_maddr", 32'(bus.mem_addr), 0);
    checkOutput("rst_mwdata", 32'(bus.mem_wdata), 0);
    checkOutput("rst_gnt", 32'(bus.gnt_id), 0);
    checkOutput("rst_busy", 32'(bus.busy), 0);
    rst = 1'b1;

    $display("[TB] single write then read-back");
    applyStimulus(2'b10, 2'b00, 16'h3C00, 16'hA500);
    tick();
    checkOutput("wr_start", 32'(bus.mem_start), 1);
    checkOutput("wr_mrw", 32'(bus.mem_rw), 0);
    checkOutput("wr_maddr", 32'(bus.mem_addr), 32'h3C);
    checkOutput("wr_mwdata", 32'(bus.mem_wdata), 32'hA5);
    checkOutput("wr_gnt", 32'(bus.gnt_id), 1);
    checkOutput("wr_ack_early", 32'(bus.ack), 0);
    applyStimulus(2'b00, 2'b00, 16'h0000, 16'h0000);
    tick();
    checkOutput("wr_ack", 32'(bus.ack), 32'b10);
    checkOutput("wr_err", 32'(bus.err), 0);
    checkOutput("wr_start_off", 32'(bus.mem_start), 0);
    tick();
    checkOutput("wr_idle", 32'(bus.busy), 0);
    checkOutput("wr_ack_off", 32'(bus.ack), 0);
    applyStimulus(2'b10, 2'b10, 16'h3C00, 16'h0000);
    tick();
    checkOutput("rd_start", 32'(bus.mem_start), 1);
    checkOutput("rd_mrw", 32'(bus.mem_rw), 1);
    applyStimulus(2'b00, 2'b00, 16'h0000, 16'h0000);
    tick();
    checkOutput("rd_ack_early", 32'(bus.ack), 0);
    tick();
    checkOutput("rd_ack", 32'(bus.ack), 32'b10);
    checkOutput("rd_rdata", 32'(bus.rdata), 32'hA5);
    checkOutput("rd_err", 32'(bus.err), 0);
    tick();
    checkOutput("rd_idle", 32'(bus.busy), 0);

    $display("[TB] contention fairness");
    applyStimulus(2'b11, 2'b11, 16'h2120, 16'h0000);
    for (int k = 0; k < 4; k++) begin
      tick();
      checkOutput("rr_gnt", 32'(bus.gnt_id), (k % 2 == 0) ? 0 : 1);
      checkOutput("rr_noack1", 32'(bus.ack), 0);
      tick();
      checkOutput("rr_noack2", 32'(bus.ack), 0);
      tick();
      checkOutput("rr_ack", 32'(bus.ack), (k % 2 == 0) ? 32'b01 : 32'b10);
      checkOutput("rr_rdata", 32'(bus.rdata), (k % 2 == 0) ? 32'h46 : 32'h47);
      tick();
      checkOutput("rr_gap", 32'(bus.ack), 0);
    end

    $display("[TB] read timeout");
    mem_en = 1'b0;
    applyStimulus(2'b01, 2'b01, 16'h0030, 16'h0000);
    for (int k = 1; k <= 17; k++) begin
      tick();
      checkOutput("to_busy", 32'(bus.busy), 1);
      checkOutput("to_noack", 32'(bus.ack), 0);
      if (k == 1) applyStimulus(2'b00, 2'b00, 16'h0000, 16'h0000);
    end
    tick();
    checkOutput("to_ack", 32'(bus.ack), 32'b01);
    checkOutput("to_err", 32'(bus.err), 1);
    checkOutput("to_rdata", 32'(bus.rdata), 0);
    checkOutput("to_busy_ack", 32'(bus.busy), 1);
    mem_en = 1'b1;
    tick();
    checkOutput("to_err_clr", 32'(bus.err), 0);
    checkOutput("to_idle", 32'(bus.busy), 0);
    applyStimulus(2'b10, 2'b10, 16'h3C00, 16'h0000);
    tick();
    applyStimulus(2'b00, 2'b00, 16'h0000, 16'h0000);
    tick(2);
    checkOutput("after_to_ack", 32'(bus.ack), 32'b10);
    checkOutput("after_to_rdata", 32'(bus.rdata), 32'hA5);
    checkOutput("after_to_err", 32'(bus.err), 0);
    tick();

    $display("[TB] rvalid on the timeout boundary");
    mem_en = 1'b0;
    applyStimulus(2'b01, 2'b01, 16'h0040, 16'h0000);
    tick();
    applyStimulus(2'b00, 2'b00, 16'h0000, 16'h0000);
    tick(16);
    checkOutput("bd_noack", 32'(bus.ack), 0);
    force_rdata  = 8'h5A;
    force_rvalid = 1'b1;
    tick();
    force_rvalid = 1'b0;
    checkOutput("bd_ack", 32'(bus.ack), 32'b01);
    checkOutput("bd_rdata", 32'(bus.rdata), 32'h5A);
    checkOutput("bd_err", 32'(bus.err), 0);
    mem_en = 1'b1;
    tick();

    $display("[TB] input stability and spurious rvalid");
    applyStimulus(2'b01, 2'b01, 16'h0010, 16'h0000);
    tick();
    checkOutput("st_maddr1", 32'(bus.mem_addr), 32'h10);
    applyStimulus(2'b01, 2'b01, 16'h0020, 16'h0000);
    tick();
    checkOutput("st_maddr2", 32'(bus.mem_addr), 32'h10);
    tick();
    checkOutput("st_ack", 32'(bus.ack), 32'b01);
    checkOutput("st_rdata", 32'(bus.rdata), 32'h76);
    checkOutput("st_maddr3", 32'(bus.mem_addr), 32'h10);
    applyStimulus(2'b00, 2'b00, 16'h0000, 16'h0000);
    tick();
    force_rdata  = 8'hEE;
    force_rvalid = 1'b1;
    tick();
    force_rvalid = 1'b0;
    checkOutput("sp_ack", 32'(bus.ack), 0);
    checkOutput("sp_rdata", 32'(bus.rdata), 32'h76);
    checkOutput("sp_busy", 32'(bus.busy), 0);

    $display("[TB] reset during a read");
    mem_en = 1'b0;
    applyStimulus(2'b10, 2'b10, 16'h5000, 16'h0000);
    tick(2);
    checkOutput("mr_busy_pre", 32'(bus.busy), 1);
    rst = 1'b0;
    tick();
    rst = 1'b1;
    checkOutput("mr_busy", 32'(bus.busy), 0);
    checkOutput("mr_ack", 32'(bus.ack), 0);
    checkOutput("mr_start", 32'(bus.mem_start), 0);
    checkOutput("mr_gnt", 32'(bus.gnt_id), 0);
    checkOutput("mr_mrw", 32'(bus.mem_rw), 1);
    checkOutput("mr_maddr", 32'(bus.mem_addr), 0);
    checkOutput("mr_rdata", 32'(bus.rdata), 0);
    mem_en = 1'b1;
    applyStimulus(2'b11, 2'b11, 16'h5150, 16'h0000);
    tick();
    checkOutput("mr_regnt", 32'(bus.gnt_id), 0);
    checkOutput("mr_remaddr", 32'(bus.mem_addr), 32'h50);
    checkOutput("mr_restart", 32'(bus.mem_start), 1);
    checkOutput("mr_noack1", 32'(bus.ack), 0);
    applyStimulus(2'b00, 2'b00, 16'h0000, 16'h0000);
    tick();
    checkOutput("mr_noack2", 32'(bus.ack), 0);
    tick();
    checkOutput("mr_reack", 32'(bus.ack), 32'b01);
    checkOutput("mr_rerdata", 32'(bus.rdata), 32'h36);
    checkOutput("mr_reerr", 32'(bus.err), 0);
    tick();
    checkOutput("mr_idle", 32'(bus.busy), 0);
    checkOutput("mr_ack_off", 32'(bus.ack), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/mem_arbiter.md
Name: mem_arbiter

Overview:
Round-robin arbiter and sequencer that shares the single 256x8 data memory between N requesters (default 2: instruction fetch and execute unit).
- Accepts one transaction at a time.
- Drives the memory's start/rW/address/write-data controls and captures read data.
- Returns a one-cycle acknowledge to the granted requester, with a watchdog against a memory that never answers.

Parameters:
N_REQ, 2, number of requesters (2..8)
AW, 8, address width
DW, 8, data width
TIMEOUT, 15, max cycles waiting for mem_rvalid before error-ack (1..255)

Ports:
CLK  in  1  clock, rising edge
RST  in  1  reset, synchronous, active-low
req  in  N_REQ  request per requester; held with its fields until ack
rw  in  N_REQ  per-requester direction, 1=read, 0=write
addr  in  N_REQ*AW  packed per-requester addresses
wdata  in  N_REQ*DW  packed per-requester write data
ack  out  N_REQ  one-hot, one-cycle completion pulse
rdata  out  DW  read data; valid only in ack cycle of a read
err  out  1  high with ack when the read timed out
busy  out  1  high in any state other than IDLE
gnt_id  out  $clog2(N_REQ)  index of the current/last granted requester
mem_start  out  1  one-cycle transaction start to memory
mem_rw  out  1  latched direction, valid while mem_start=1
mem_addr  out  AW  latched address, held from ISSUE through ACK
mem_wdata  out  DW  latched write data, valid while mem_start=1
mem_rdata  in  DW  memory read data
mem_rvalid  in  1  memory read data valid (one cycle)

Behaviour:
- Clock and reset: one clock CLK; reset RST is synchronous and active-low. All state updates occur on the rising edge of CLK only.
- Reset (RST=0 at an edge):
  - state=IDLE; rr_ptr=0; ack=0; err=0.
  - rdata=0; mem_start=0; mem_rw=1; mem_addr=0; mem_wdata=0; gnt_id=0.
  - Reset mid-transaction abandons it silently: no ack, and the memory may already have written.
- IDLE:
  - If any req is high, select the first requester at or after rr_ptr, wrapping modulo N_REQ.
  - Latch its rw/addr/wdata; set gnt_id; go to ISSUE.
  - If no req is high, stay in IDLE.
- ISSUE (exactly 1 cycle):
  - mem_start=1, driven from the latched values.
  - If read: clear the watchdog counter and go to WAIT.
  - If write: go to ACK.
- WAIT:
  - If mem_rvalid=1: capture mem_rdata into rdata and go to ACK with err=0.
  - Otherwise increment the counter. When the counter reaches TIMEOUT, go to ACK with err=1 and rdata=0.
  - mem_rvalid arriving in the same cycle as the timeout has priority: data is taken, err=0.
- ACK (exactly 1 cycle):
  - ack[gnt_id]=1; rdata and err are valid.
  - rr_ptr <= (gnt_id+1) mod N_REQ; go to IDLE.
  - err is 0 for writes.
- mem_rvalid outside WAIT is ignored. mem_rdata is sampled only in WAIT.
- Changes to req/rw/addr/wdata after the grant have no effect; values are latched in IDLE.
- A requester that keeps req high after its ack is treated as a new request. Round-robin order still gives every other pending requester a turn first.
- A requester dropping req before its ack does not cancel the transaction; the ack is still issued.
- Latency from the cycle req is sampled in IDLE:
  - Write: ack 2 cycles later.
  - Read with a one-cycle memory: mem_start at +1, mem_rvalid at +2, ack at +3.
- Throughput: one transaction per 3 (write) or 4 (read) cycles; no pipelining.
- Outputs ack, err, rdata and mem_* are registered. busy is decoded from state.

Decomposition:
- Package ay8_mem_pkg:
  - RW_READ=1'b1, RW_WRITE=1'b0.
  - typedef enum logic [1:0] {ARB_IDLE, ARB_ISSUE, ARB_WAIT, ARB_ACK} arb_state_t.
  - Shared with the memory and the CPU requesters.
- Sub-module rr_pick (combinational): inputs req and rr_ptr; outputs a valid flag and the winning index. It is instantiated once in mem_arbiter.

Test Plan:
- Single write: req[1]=1, rw=0, addr=8'h3C, wdata=8'hA5 -> mem_start pulse with mem_rw=0, mem_addr=3C, mem_wdata=A5 one cycle later; ack=2'b10 two cycles after sample; a following read of 3C returns rdata=A5, err=0, ack at +3.
- Contention fairness: req=2'b11, both reads, held continuously after reset -> grant order 0,1,0,1; each ack one-hot; no requester served twice in a row.
- Read timeout: memory model never raises mem_rvalid, TIMEOUT=15 -> ack with err=1 and rdata=0 exactly 1+1+15+1 cycles after sample; busy high throughout; next request served normally.
- Late rvalid on the boundary: mem_rvalid asserted in the same cycle the counter hits TIMEOUT with mem_rdata=8'h5A -> rdata=5A, err=0.
- Input stability: change addr[0] from 10 to 20 one cycle after grant -> mem_addr stays 10; spurious mem_rvalid while in IDLE -> no ack, rdata unchanged.
- Reset mid-read: RST=0 for one edge while in WAIT -> next cycle state=IDLE, ack=0, mem_start=0, rr_ptr=0; no ack ever issued for the aborted read.
